// File: rtl/hv2000_level_expander_pkg.sv
// Shared types and constants for the 2000-bit level hypervector expander.
// Also holds the saturation helpers used when loading and advancing the remaining count.
package hv_pkg;

  localparam int HV_DIM     = 2000;
  localparam int CHUNK      = 100;
  localparam int NUM_CHUNKS = HV_DIM / CHUNK;
  localparam int IDX_W      = 5;
  localparam int WEIGHT_W   = 11;

  typedef enum logic {IDLE, EMIT} lvl_state_t;

  typedef logic [CHUNK-1:0]    chunk_t;
  typedef logic [WEIGHT_W-1:0] weight_t;
  typedef logic [IDX_W-1:0]    idx_t;
  typedef logic [HV_DIM-1:0]   hv_t;

  // Requests above HV_DIM flip the whole vector.
  function automatic weight_t sat_weight(input weight_t w);
    return (w > weight_t'(HV_DIM)) ? weight_t'(HV_DIM) : w;
  endfunction

  // Remaining count for the next slice, floored at zero.
  function automatic weight_t sat_sub_chunk(input weight_t r);
    return (r >= weight_t'(CHUNK)) ? r - weight_t'(CHUNK) : '0;
  endfunction

endpackage

// File: rtl/hv2000_level_expander_thermo_mask_gen.sv
// Thermometer mask for one slice: bit j set when j < remaining_in.
// Saturates to all ones once remaining_in reaches CHUNK.
module thermo_mask_gen
  import hv_pkg::*;
(
  input  weight_t remaining_in,
  output chunk_t  mask_out
);

  always_comb begin
    mask_out = '0;
    for (int j = 0; j < CHUNK; j++) begin
      mask_out[j] = (remaining_in > weight_t'(j));
    end
  end

endmodule

// File: rtl/hv2000_level_expander.sv
// Expands a scalar weight into base XOR thermometer, streamed as CHUNK-bit slices.
// One request at a time; every output comes straight from a flop.
module hv2000_level_expander
  import hv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                weight_valid_in,
  output logic                weight_ready_out,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic [HV_DIM-1:0]   base_hv_in,
  output logic                chunk_valid_out,
  input  logic                chunk_ready_in,
  output logic [CHUNK-1:0]    chunk_out,
  output logic [IDX_W-1:0]    chunk_idx_out,
  output logic                chunk_last_out
);

  lvl_state_t state_q, state_d;
  hv_t        base_q, base_d;
  weight_t    remaining_q, remaining_d;
  logic       valid_q, valid_d;
  chunk_t     chunk_q, chunk_d;
  idx_t       idx_q, idx_d;
  logic       last_q, last_d;

  logic       accept;
  logic       beat_xfer;
  weight_t    mask_rem;
  chunk_t     slice_src;
  chunk_t     mask;

  assign accept    = (state_q == IDLE) && weight_valid_in;
  assign beat_xfer = valid_q && chunk_ready_in;

  // base_q is kept pre-shifted so the next slice is always its low CHUNK bits,
  // which avoids a variable part-select (and the multiply behind it).
  always_comb begin
    mask_rem  = accept ? sat_weight(weight_in) : sat_sub_chunk(remaining_q);
    slice_src = accept ? base_hv_in[CHUNK-1:0] : base_q[CHUNK-1:0];
  end

  thermo_mask_gen u_thermo_mask_gen (
    .remaining_in (mask_rem),
    .mask_out     (mask)
  );

  always_comb begin
    // NOTE: every _d starts at its current value so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    chunk_d     = chunk_q;
    idx_d       = idx_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        if (weight_valid_in) begin
          state_d     = EMIT;
          base_d      = base_hv_in >> CHUNK;
          remaining_d = mask_rem;
          chunk_d     = slice_src ^ mask;
          idx_d       = '0;
          last_d      = (NUM_CHUNKS == 1);
          valid_d     = 1'b1;
        end
      end
      EMIT: begin
        if (beat_xfer) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            base_d      = base_q >> CHUNK;
            remaining_d = mask_rem;
            chunk_d     = slice_src ^ mask;
            idx_d       = idx_q + idx_t'(1);
            last_d      = (idx_q == idx_t'(NUM_CHUNKS - 2));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset is asynchronous and applies to all registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      chunk_q     <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      chunk_q     <= chunk_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign weight_ready_out = (state_q == IDLE);
  assign chunk_valid_out  = valid_q;
  assign chunk_out        = chunk_q;
  assign chunk_idx_out    = idx_q;
  assign chunk_last_out   = last_q;

endmodule

// File: tb/tb_hv2000_level_expander.sv
// Self-checking bench: bit-level reference model of base XOR thermometer,
// a negedge monitor scoring every transferred slice, plus directed literal checks.
module tb_hv2000_level_expander;
  import hv_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                weight_valid_in;
  logic                weight_ready_out;
  logic [WEIGHT_W-1:0] weight_in;
  logic [HV_DIM-1:0]   base_hv_in;
  logic                chunk_valid_out;
  logic                chunk_ready_in;
  logic [CHUNK-1:0]    chunk_out;
  logic [IDX_W-1:0]    chunk_idx_out;
  logic                chunk_last_out;

  weight_t tm_rem;
  chunk_t  tm_mask;

  always #5 clk = ~clk;

  hv2000_level_expander dut (
    .clk              (clk),
    .rst              (rst),
    .weight_valid_in  (weight_valid_in),
    .weight_ready_out (weight_ready_out),
    .weight_in        (weight_in),
    .base_hv_in       (base_hv_in),
    .chunk_valid_out  (chunk_valid_out),
    .chunk_ready_in   (chunk_ready_in),
    .chunk_out        (chunk_out),
    .chunk_idx_out    (chunk_idx_out),
    .chunk_last_out   (chunk_last_out)
  );

  thermo_mask_gen u_tm (
    .remaining_in (tm_rem),
    .mask_out     (tm_mask)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input hv_t act, input hv_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: %0d bits differ, got low slice %0h expected %0h",
               name, $countones(act ^ exp), act[CHUNK-1:0], exp[CHUNK-1:0]);
    end
  endtask

  // Reference: flip the first min(w, HV_DIM) bits of base.
  function automatic hv_t level_vec(input hv_t base, input int w);
    hv_t v;
    int  n;
    v = base;
    n = (w > HV_DIM) ? HV_DIM : w;
    for (int i = 0; i < n; i++) v[i] = ~v[i];
    return v;
  endfunction

  function automatic hv_t random_hv();
    hv_t v;
    for (int i = 0; i < HV_DIM; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Monitor / scoreboard
  hv_t    exp_q[$];
  hv_t    done_q[$];
  int     accept_cyc[$];
  int     cyc = 0;
  int     cur_beat = 0;
  hv_t    cur_vec;
  hv_t    head_vec;
  int     low_cnt = 0;
  logic   prev_stall = 1'b0;
  chunk_t prev_chunk;
  idx_t   prev_idx;
  logic   prev_last;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      cur_beat   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", 128'(chunk_valid_out), 128'd1);
        check("stall_data_hold", {chunk_last_out, chunk_idx_out, chunk_out},
              {prev_last, prev_idx, prev_chunk});
      end
      if (!weight_ready_out) low_cnt++;
      if (chunk_valid_out && chunk_ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_without_request: idx %0d emitted with no pending request", chunk_idx_out);
        end else begin
          head_vec = exp_q[0];
          check("beat_idx", 128'(chunk_idx_out), 128'(cur_beat));
          check("beat_last", 128'(chunk_last_out), 128'(cur_beat == NUM_CHUNKS - 1));
          check("beat_data", 128'(chunk_out), 128'(head_vec[cur_beat*CHUNK +: CHUNK]));
          cur_vec[cur_beat*CHUNK +: CHUNK] = chunk_out;
          cur_beat++;
          if (cur_beat == NUM_CHUNKS) begin
            done_q.push_back(cur_vec);
            void'(exp_q.pop_front());
            cur_beat = 0;
          end
        end
      end
      prev_stall = chunk_valid_out && !chunk_ready_in;
      prev_chunk = chunk_out;
      prev_idx   = chunk_idx_out;
      prev_last  = chunk_last_out;
      if (weight_ready_out && weight_valid_in) begin
        exp_q.push_back(level_vec(base_hv_in, int'(weight_in)));
        accept_cyc.push_back(cyc);
        low_cnt = 0;
      end
    end
  end

  // Downstream ready: percentage duty, re-drawn every cycle
  int ready_pct = 100;
  initial begin
    chunk_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      chunk_ready_in = ($urandom_range(0, 99) < ready_pct);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the edge on which ready was high.
  task automatic wait_accept();
    logic r;
    int   n;
    n = 0;
    forever begin
      r = weight_ready_out;
      tick();
      if (r) break;
      n++;
      if (n > 2000) begin
        check("accept_timeout", 128'd1, 128'd0 + 128'(r));
        break;
      end
    end
  endtask

  task automatic send(input int w, input hv_t base);
    weight_in       = WEIGHT_W'(w);
    base_hv_in      = base;
    weight_valid_in = 1'b1;
    wait_accept();
    weight_valid_in = 1'b0;
    base_hv_in      = random_hv();
    weight_in       = WEIGHT_W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(weight_ready_out && exp_q.size() == 0)) begin
      tick();
      n++;
      if (n > 3000) begin
        check("drain_timeout_pending", 128'(exp_q.size()), 128'd0);
        break;
      end
    end
  endtask

  hv_t    b, b2, alt, e;
  hv_t    v, v1, v2;
  chunk_t s;
  int     n_done;
  int     w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    weight_valid_in = 1'b0;
    weight_in       = '0;
    base_hv_in      = '0;
    tm_rem          = '0;
    #1;
    check("rst_ready", 128'(weight_ready_out), 128'd1);
    check("rst_valid", 128'(chunk_valid_out), 128'd0);
    check("rst_outputs", {chunk_last_out, chunk_idx_out, chunk_out}, 128'd0);

    // Standalone mask generator
    tm_rem = 11'd0;    #1; check("tm_0", 128'(tm_mask), 128'd0);
    tm_rem = 11'd37;   #1; check("tm_37", 128'(tm_mask), (128'd1 << 37) - 128'd1);
    tm_rem = 11'd99;   #1; check("tm_99", 128'(tm_mask), (128'd1 << 99) - 128'd1);
    tm_rem = 11'd100;  #1; check("tm_100", 128'(tm_mask), (128'd1 << 100) - 128'd1);
    tm_rem = 11'd2000; #1; check("tm_2000", 128'(tm_mask), (128'd1 << 100) - 128'd1);

    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Weight 150 on zero base
    ready_pct = 100;
    send(150, '0);
    wait_idle();
    v = done_q[$];
    check("w150_slice0", 128'(v[99:0]), (128'd1 << 100) - 128'd1);
    check("w150_slice1", 128'(v[199:100]), (128'd1 << 50) - 128'd1);
    e = '0;
    e[149:0] = '1;
    check_vec("w150_vector", v, e);
    check("w150_popcount", 128'($countones(v)), 128'd150);

    // Alternating base, weights 0 and 2000
    for (int i = 0; i < HV_DIM; i++) alt[i] = ~i[0];
    send(0, alt);
    wait_idle();
    check_vec("w0_equals_base", done_q[$], alt);
    check("w0_ready_low_cycles", 128'(low_cnt), 128'(NUM_CHUNKS));
    send(2000, alt);
    wait_idle();
    check_vec("w2000_equals_not_base", done_q[$], ~alt);
    check("w2000_ready_low_cycles", 128'(low_cnt), 128'(NUM_CHUNKS));

    // Saturation and chunk-aligned boundaries
    b = random_hv();
    send(2047, b);
    wait_idle();
    check_vec("w2047_saturates", done_q[$], ~b);
    send(100, b);
    wait_idle();
    v = done_q[$];
    s = ~b[99:0];
    check("w100_slice0_flipped", 128'(v[99:0]), 128'(s));
    check("w100_slice1_untouched", 128'(v[199:100]), 128'(b[199:100]));
    send(1900, b);
    wait_idle();
    v = done_q[$];
    s = ~b[1899:1800];
    check("w1900_slice18_flipped", 128'(v[1899:1800]), 128'(s));
    check("w1900_slice19_untouched", 128'(v[1999:1900]), 128'(b[1999:1900]));

    // Backpressure at 30% with weight_valid_in noise during EMIT
    ready_pct = 30;
    b = random_hv();
    n_done = done_q.size();
    send(777, b);
    repeat (15) begin
      weight_valid_in = 1'($urandom_range(0, 1));
      weight_in       = WEIGHT_W'($urandom);
      base_hv_in      = random_hv();
      tick();
    end
    weight_valid_in = 1'b0;
    wait_idle();
    check("bp_vector_count", 128'(done_q.size()), 128'(n_done + 1));
    check_vec("bp_w777_vector", done_q[$], level_vec(b, 777));
    ready_pct = 100;

    // Reset during beat 7
    b = random_hv();
    n_done = done_q.size();
    send(600, b);
    begin
      int n;
      n = 0;
      while (!(chunk_valid_out && chunk_idx_out == idx_t'(7)) && n < 200) begin
        tick();
        n++;
      end
      check("reach_beat7_idx", 128'(chunk_idx_out), 128'd7);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 128'(chunk_valid_out), 128'd0);
    check("midrst_outputs", {chunk_last_out, chunk_idx_out, chunk_out}, 128'd0);
    check("midrst_ready", 128'(weight_ready_out), 128'd1);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("postrst_no_beats", 128'(chunk_valid_out), 128'd0);
    check("postrst_ready", 128'(weight_ready_out), 128'd1);
    check("postrst_no_vector", 128'(done_q.size()), 128'(n_done));
    b2 = random_hv();
    send(5, b2);
    wait_idle();
    v = done_q[$];
    s = b2[99:0] ^ chunk_t'(5'b11111);
    check("w5_slice0", 128'(v[99:0]), 128'(s));
    check_vec("w5_vector", v, level_vec(b2, 5));

    // Back-to-back: valid held high, weights 10 then 1990
    b  = random_hv();
    b2 = random_hv();
    weight_in       = 11'd10;
    base_hv_in      = b;
    weight_valid_in = 1'b1;
    wait_accept();
    weight_in  = 11'd1990;
    base_hv_in = b2;
    wait_accept();
    weight_valid_in = 1'b0;
    wait_idle();
    check("b2b_spacing", 128'(accept_cyc[$] - accept_cyc[$-1]), 128'(NUM_CHUNKS + 1));
    v1 = done_q[$-1];
    v2 = done_q[$];
    check("b2b_first_flips", 128'($countones(v1 ^ b)), 128'd10);
    check("b2b_second_flips", 128'($countones(v2 ^ b2)), 128'd1990);
    check_vec("b2b_first_vector", v1, level_vec(b, 10));
    check_vec("b2b_second_vector", v2, level_vec(b2, 1990));

    // Random requests under random backpressure
    for (int k = 0; k < 8; k++) begin
      ready_pct = $urandom_range(20, 100);
      w = $urandom_range(0, 2047);
      b = random_hv();
      send(w, b);
      wait_idle();
      check_vec("rand_vector", done_q[$], level_vec(b, w));
    end
    ready_pct = 100;

    repeat (3) tick();
    check("end_no_pending", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
